// File: rtl/soc_system_power_pkg.sv
// Shared types and defaults for the power pushbutton conditioner.
package soc_system_power_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        LONG_HELD  = 3'd3,
        DB_RELEASE = 3'd4
    } power_btn_state_t;

    localparam int POWER_DEBOUNCE_CYCLES_DEF  = 50000;
    localparam int POWER_LONGPRESS_CYCLES_DEF = 150000000;

    function automatic logic is_held_state(input power_btn_state_t s);
        return (s == PRESSED) || (s == LONG_HELD) || (s == DB_RELEASE);
    endfunction

endpackage

// File: rtl/soc_system_power_sync.sv
// Two-flop synchroniser for asynchronous PIO inputs; the reset level is
// chosen by the instantiator so a reset never looks like an event.
module soc_system_power_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= {2{RST_VAL}};
        end else begin
            sync_ff <= {sync_ff[0], d};
        end
    end

    assign q = sync_ff[1];

endmodule

// File: rtl/soc_system_power_button.sv
// Power pushbutton conditioner: synchronise, debounce, classify short/long press.
// Optional press counter output is built when SOC_SYSTEM_POWER_BTN_CNT_EN is defined.
//
// state      | meaning
// IDLE       | button released and settled
// DB_PRESS   | press seen, waiting for it to stay stable
// PRESSED    | accepted press, timing towards a long press
// LONG_HELD  | press held past the long-press limit, forcing power off
// DB_RELEASE | release seen, waiting for it to stay stable
module soc_system_power_button
    import soc_system_power_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = POWER_DEBOUNCE_CYCLES_DEF,
    parameter int LONGPRESS_CYCLES = POWER_LONGPRESS_CYCLES_DEF,
    parameter bit BTN_ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button_raw,
    input  logic       power_ack,
    output logic       power_req,
    output logic       force_off,
`ifdef SOC_SYSTEM_POWER_BTN_CNT_EN
    output logic [7:0] press_count,
`endif
    output logic       btn_pressed
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONGPRESS_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS_CYCLES - 1);

    logic raw_s;
    logic btn_s;

    // Synchroniser resets to the released pin level so reset never reads as a press.
    soc_system_power_sync #(
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (button_raw),
        .q       (raw_s)
    );

    assign btn_s = raw_s ^ BTN_ACTIVE_LOW;

    power_btn_state_t  state, state_nx;
    logic [DB_W-1:0]   db_cnt, db_cnt_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic              was_long, was_long_nx;
    logic              set_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            db_cnt   <= '0;
            hold_cnt <= '0;
            was_long <= 1'b0;
        end else begin
            state    <= state_nx;
            db_cnt   <= db_cnt_nx;
            hold_cnt <= hold_cnt_nx;
            was_long <= was_long_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        db_cnt_nx   = db_cnt;
        hold_cnt_nx = hold_cnt;
        was_long_nx = was_long;
        set_req     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nx  = DB_PRESS;
                    db_cnt_nx = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nx    = PRESSED;
                    hold_cnt_nx = '0;
                end else begin
                    db_cnt_nx = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nx    = DB_RELEASE;
                    was_long_nx = 1'b0;
                    db_cnt_nx   = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx = LONG_HELD;
                end else begin
                    hold_cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (!btn_s) begin
                    state_nx    = DB_RELEASE;
                    was_long_nx = 1'b1;
                    db_cnt_nx   = '0;
                end
            end
            DB_RELEASE: begin
                // A bounce back to pressed resumes timing where it left off.
                if (btn_s) begin
                    state_nx = was_long ? LONG_HELD : PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nx = IDLE;
                    set_req  = !was_long;
                end else begin
                    db_cnt_nx = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_pressed <= 1'b0;
            force_off   <= 1'b0;
            power_req   <= 1'b0;
        end else begin
            btn_pressed <= is_held_state(state_nx);
            force_off   <= (state_nx == LONG_HELD) ||
                           ((state_nx == DB_RELEASE) && was_long_nx);
            if (power_ack) begin
                power_req <= 1'b0;
            end else if (set_req) begin
                power_req <= 1'b1;
            end
        end
    end

`ifdef SOC_SYSTEM_POWER_BTN_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_count <= 8'd0;
        end else if (set_req && (press_count != 8'hFF)) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule
